// File: rtl/branch_sched.sv
// Branch resolution scheduler for the MIPS ID stage: waits for operands, evaluates, issues a one-cycle redirect.
// Optional macro BR_EXT_EN adds bne/blez/bgtz/bltz decoding; default build decodes beq/bgez only.
module branch_sched #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_type,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_offset,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rs_pend,
  input  logic        rt_pend,
  input  logic        fwd_rs_valid,
  input  logic        fwd_rt_valid,
  input  logic [31:0] fwd_rs_data,
  input  logic [31:0] fwd_rt_data,
  output logic        stall,
  output logic        redir_valid,
  output logic        redir_taken,
  output logic [31:0] redir_target,
  output logic        err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_OPND, S_RESP} state_t;

  localparam logic [2:0] BT_BEQ  = 3'b000;
  localparam logic [2:0] BT_BGEZ = 3'b001;
`ifdef BR_EXT_EN
  localparam logic [2:0] BT_BNE  = 3'b010;
  localparam logic [2:0] BT_BLEZ = 3'b011;
  localparam logic [2:0] BT_BGTZ = 3'b100;
  localparam logic [2:0] BT_BLTZ = 3'b101;
`endif
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        br_ready_q, br_ready_d;
  logic        stall_q, stall_d;
  logic        redir_valid_q, redir_valid_d;
  logic        redir_taken_q, redir_taken_d;
  logic [31:0] redir_target_q, redir_target_d;
  logic        err_q, err_d;

  logic        need_rs, need_rt;
  logic        rs_ok, rt_ok, all_ok;
  logic [31:0] rs_val, rt_val;
  logic        op_eq, rs_neg, rs_zero, cond;
  logic [31:0] tgt_taken, tgt_fall;
  logic [7:0]  cnt_inc;

  // Forwarded data wins whenever it is offered; register data is only trusted once pend drops.
  assign rs_ok  = !rs_pend || fwd_rs_valid;
  assign rt_ok  = !rt_pend || fwd_rt_valid;
  assign rs_val = fwd_rs_valid ? fwd_rs_data : rs_data;
  assign rt_val = fwd_rt_valid ? fwd_rt_data : rt_data;

  assign op_eq   = (rs_val == rt_val);
  assign rs_neg  = rs_val[31];
  assign rs_zero = (rs_val == 32'd0);

  assign tgt_taken = pc_q + 32'd4 + {{14{off_q[15]}}, off_q, 2'b00};
  assign tgt_fall  = pc_q + 32'd8;
  assign cnt_inc   = cnt_q + 8'd1;

  // Undecoded types need no operands and evaluate not-taken on the first OPND cycle.
  always_comb begin
    need_rs = 1'b0;
    need_rt = 1'b0;
    cond    = 1'b0;
    case (type_q)
      BT_BEQ:  begin need_rs = 1'b1; need_rt = 1'b1; cond = op_eq; end
      BT_BGEZ: begin need_rs = 1'b1; cond = !rs_neg; end
`ifdef BR_EXT_EN
      BT_BNE:  begin need_rs = 1'b1; need_rt = 1'b1; cond = !op_eq; end
      BT_BLEZ: begin need_rs = 1'b1; cond = rs_neg || rs_zero; end
      BT_BGTZ: begin need_rs = 1'b1; cond = !rs_neg && !rs_zero; end
      BT_BLTZ: begin need_rs = 1'b1; cond = rs_neg; end
`endif
      default: begin need_rs = 1'b0; need_rt = 1'b0; cond = 1'b0; end
    endcase
  end

  assign all_ok = (!need_rs || rs_ok) && (!need_rt || rt_ok);

  always_comb begin
    state_d        = state_q;
    type_d         = type_q;
    pc_d           = pc_q;
    off_d          = off_q;
    cnt_d          = cnt_q;
    br_ready_d     = br_ready_q;
    stall_d        = stall_q;
    redir_valid_d  = redir_valid_q;
    redir_taken_d  = redir_taken_q;
    redir_target_d = redir_target_q;
    err_d          = err_q;
    case (state_q)
      S_IDLE: begin
        if (br_valid) begin
          type_d     = br_type;
          pc_d       = br_pc;
          off_d      = br_offset;
          cnt_d      = 8'd0;
          state_d    = S_OPND;
          br_ready_d = 1'b0;
          stall_d    = 1'b1;
        end
      end
      S_OPND: begin
        if (all_ok) begin
          redir_taken_d  = cond;
          redir_target_d = cond ? tgt_taken : tgt_fall;
          redir_valid_d  = 1'b1;
          state_d        = S_RESP;
        end else if (cnt_inc == WAIT_LIM) begin
          // This was the last permitted wait cycle: give up and fall through.
          err_d          = 1'b1;
          redir_taken_d  = 1'b0;
          redir_target_d = tgt_fall;
          redir_valid_d  = 1'b1;
          state_d        = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        redir_valid_d = 1'b0;
        stall_d       = 1'b0;
        br_ready_d    = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        redir_valid_d = 1'b0;
        stall_d       = 1'b0;
        br_ready_d    = 1'b1;
        state_d       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      type_q         <= 3'd0;
      pc_q           <= 32'd0;
      off_q          <= 16'd0;
      cnt_q          <= 8'd0;
      br_ready_q     <= 1'b1;
      stall_q        <= 1'b0;
      redir_valid_q  <= 1'b0;
      redir_taken_q  <= 1'b0;
      redir_target_q <= 32'd0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      type_q         <= type_d;
      pc_q           <= pc_d;
      off_q          <= off_d;
      cnt_q          <= cnt_d;
      br_ready_q     <= br_ready_d;
      stall_q        <= stall_d;
      redir_valid_q  <= redir_valid_d;
      redir_taken_q  <= redir_taken_d;
      redir_target_q <= redir_target_d;
      err_q          <= err_d;
    end
  end

  assign br_ready     = br_ready_q;
  assign stall        = stall_q;
  assign redir_valid  = redir_valid_q;
  assign redir_taken  = redir_taken_q;
  assign redir_target = redir_target_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_branch_sched.sv
// Randomized self-checking bench for branch_sched: transaction-level model plus per-cycle compare.
module tb_branch_sched;
  localparam int WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_type;
  logic [31:0] br_pc;
  logic [15:0] br_offset;
  logic [31:0] rs_data, rt_data, fwd_rs_data, fwd_rt_data;
  logic        rs_pend, rt_pend, fwd_rs_valid, fwd_rt_valid;
  logic        stall, redir_valid, redir_taken, err_timeout;
  logic [31:0] redir_target;

  branch_sched #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .br_ready(br_ready), .br_type(br_type),
    .br_pc(br_pc), .br_offset(br_offset),
    .rs_data(rs_data), .rt_data(rt_data),
    .rs_pend(rs_pend), .rt_pend(rt_pend),
    .fwd_rs_valid(fwd_rs_valid), .fwd_rt_valid(fwd_rt_valid),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .stall(stall), .redir_valid(redir_valid), .redir_taken(redir_taken),
    .redir_target(redir_target), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit          chk_en = 1'b0;
  logic        exp_ready = 1'b1, exp_stall = 1'b0, exp_valid = 1'b0;
  logic        exp_taken = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_target = 32'd0;
  logic        last_taken = 1'b0;
  logic [31:0] last_target = 32'd0;
  int          stall_run = 0, last_stall_len = 0;
  int          n_redir = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("br_ready", 32'(br_ready), 32'(exp_ready));
      check("stall", 32'(stall), 32'(exp_stall));
      check("redir_valid", 32'(redir_valid), 32'(exp_valid));
      check("err_timeout", 32'(err_timeout), 32'(exp_err));
      if (exp_valid) begin
        check("redir_taken", 32'(redir_taken), 32'(exp_taken));
        check("redir_target", redir_target, exp_target);
      end
    end
    if (redir_valid) begin
      last_taken  = redir_taken;
      last_target = redir_target;
      n_redir++;
    end
    if (stall) stall_run++;
    else if (stall_run != 0) begin
      last_stall_len = stall_run;
      stall_run = 0;
    end
  end

  // ---------------- behavioural model ----------------
  function automatic bit ext_en();
`ifdef BR_EXT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit decoded(input logic [2:0] t);
    return (t <= 3'd1) || (ext_en() && t <= 3'd5);
  endfunction

  function automatic void needs(input logic [2:0] t, output bit nrs, output bit nrt);
    nrs = decoded(t);
    nrt = decoded(t) && (t == 3'd0 || t == 3'd2);
  endfunction

  function automatic bit br_cond(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    int signed s;
    s = a;
    case (t)
      3'd0: return a == b;
      3'd1: return s >= 0;
      3'd2: return a != b;
      3'd3: return s <= 0;
      3'd4: return s > 0;
      3'd5: return s < 0;
      default: return 1'b0;
    endcase
  endfunction

  // mode 0: pend drops and register value used; 1: fwd with pend held; 2: fwd with pend low
  task automatic drive_opnd(input int j, input int r, input int mode, input logic [31:0] val,
                            output logic pend, output logic fv,
                            output logic [31:0] d, output logic [31:0] fd);
    d  = $urandom;
    fd = $urandom;
    if (j < r) begin
      pend = 1'b1;
      fv   = 1'b0;
    end else if (mode == 0) begin
      pend = 1'b0;
      fv   = 1'b0;
      d    = val;
    end else begin
      pend = (mode == 1);
      fv   = 1'b1;
      fd   = val;
    end
  endtask

  task automatic junk_inputs(input bit allow_valid);
    br_valid     = allow_valid ? 1'($urandom) : 1'b0;
    br_type      = 3'($urandom);
    br_pc        = $urandom;
    br_offset    = 16'($urandom);
    rs_data      = $urandom;
    rt_data      = $urandom;
    fwd_rs_data  = $urandom;
    fwd_rt_data  = $urandom;
    rs_pend      = 1'($urandom);
    rt_pend      = 1'($urandom);
    fwd_rs_valid = 1'($urandom);
    fwd_rt_valid = 1'($urandom);
  endtask

  task automatic set_idle_exp();
    exp_ready = 1'b1;
    exp_stall = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      set_idle_exp();
      junk_inputs(1'b0);
      @(posedge clk); #1;
    end
    set_idle_exp();
    br_valid = 1'b0;
  endtask

  // One whole branch: accept cycle, OPND cycles, RESP cycle. Enter and leave in an idle cycle.
  task automatic do_br(input logic [2:0] t, input logic [31:0] pc, input logic [15:0] off,
                       input logic [31:0] rsv, input logic [31:0] rtv,
                       input int r_rs, input int m_rs, input int r_rt, input int m_rt);
    bit nrs, nrt, to, tk;
    int r, n, so;
    logic [31:0] tgt;
    set_idle_exp();
    junk_inputs(1'b0);
    br_valid = 1'b1; br_type = t; br_pc = pc; br_offset = off;
    @(posedge clk); #1;
    needs(t, nrs, nrt);
    r = 1;
    if (nrs) r = r_rs;
    if (nrt && r_rt > r) r = r_rt;
    to = (r > WAIT_MAX);
    n  = to ? WAIT_MAX : r;
    tk = !to && br_cond(t, rsv, rtv) && decoded(t);
    so = int'($signed(off));
    tgt = tk ? (pc + 32'd4 + 32'(so * 4)) : (pc + 32'd8);
    for (int j = 1; j <= n; j++) begin
      exp_ready = 1'b0; exp_stall = 1'b1; exp_valid = 1'b0;
      junk_inputs(1'b1);
      drive_opnd(j, r_rs, m_rs, rsv, rs_pend, fwd_rs_valid, rs_data, fwd_rs_data);
      drive_opnd(j, r_rt, m_rt, rtv, rt_pend, fwd_rt_valid, rt_data, fwd_rt_data);
      @(posedge clk); #1;
    end
    exp_ready = 1'b0; exp_stall = 1'b1; exp_valid = 1'b1;
    exp_taken = tk; exp_target = tgt;
    if (to) exp_err = 1'b1;
    junk_inputs(1'b1);
    @(posedge clk); #1;
    set_idle_exp();
    junk_inputs(1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    int redir_before;
    rst_n = 1'b0;
    junk_inputs(1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_target", redir_target, 32'd0);
    check("reset_taken", 32'(redir_taken), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // beq equal operands, no pend
    do_br(3'd0, 32'h0000_3000, 16'h0004, 32'd5, 32'd5, 1, 0, 1, 0);
    check("beq_taken", 32'(last_taken), 32'd1);
    check("beq_target", last_target, 32'h0000_3014);
    idle(1);
    check("beq_stall_len", 32'(last_stall_len), 32'd2);

    // bgez negative then zero
    do_br(3'd1, 32'h0000_4000, 16'h0010, 32'h8000_0000, 32'd0, 1, 0, 1, 0);
    check("bgez_neg_taken", 32'(last_taken), 32'd0);
    check("bgez_neg_target", last_target, 32'h0000_4008);
    do_br(3'd1, 32'h0000_5000, 16'h0010, 32'd0, 32'd7, 1, 0, 1, 0);
    check("bgez_zero_taken", 32'(last_taken), 32'd1);
    check("bgez_zero_target", last_target, 32'h0000_5044);

    // rs pending 3 cycles, then forwarded value matching rt
    do_br(3'd0, 32'h0000_6000, 16'hFFFF, 32'h0000_1234, 32'h0000_1234, 4, 1, 1, 0);
    check("fwd_taken", 32'(last_taken), 32'd1);
    check("fwd_target", last_target, 32'h0000_6000);
    idle(1);
    check("fwd_stall_len", 32'(last_stall_len), 32'd5);

    // rt never resolves: timeout
    do_br(3'd0, 32'h0000_7000, 16'h0020, 32'd1, 32'd1, 1, 0, 100, 0);
    check("to_taken", 32'(last_taken), 32'd0);
    check("to_target", last_target, 32'h0000_7008);
    check("to_err", 32'(err_timeout), 32'd1);
    idle(1);
    check("to_stall_len", 32'(last_stall_len), 32'd5);
    do_br(3'd1, 32'h0000_8000, 16'h0000, 32'd3, 32'd0, 1, 0, 1, 0);
    check("err_sticky", 32'(err_timeout), 32'd1);

    // target wrap and negative offset
    do_br(3'd0, 32'hFFFF_FFF0, 16'h0008, 32'd9, 32'd9, 1, 0, 1, 0);
    check("wrap_target", last_target, 32'h0000_0014);
    do_br(3'd0, 32'h0010_0000, 16'h8000, 32'd9, 32'd9, 1, 2, 1, 2);
    check("negoff_target", last_target, 32'h000E_0004);

    // reset pulsed mid-OPND: no redirect, error cleared
    redir_before = n_redir;
    set_idle_exp();
    junk_inputs(1'b0);
    br_valid = 1'b1; br_type = 3'd0; br_pc = 32'h0000_9000; br_offset = 16'h0001;
    @(posedge clk); #1;
    exp_ready = 1'b0; exp_stall = 1'b1; exp_valid = 1'b0;
    br_valid = 1'b0;
    rs_pend = 1'b1; rt_pend = 1'b1; fwd_rs_valid = 1'b0; fwd_rt_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    set_idle_exp();
    exp_err = 1'b0;
    rs_pend = 1'b0; rt_pend = 1'b0; rs_data = 32'd4; rt_data = 32'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    check("rst_no_redir", 32'(n_redir - redir_before), 32'd0);
    check("rst_err_clear", 32'(err_timeout), 32'd0);
    check("rst_target_clear", redir_target, 32'd0);

`ifdef BR_EXT_EN
    do_br(3'd5, 32'h0000_A000, 16'h0002, 32'hFFFF_FFFF, 32'd0, 1, 0, 1, 0);
    check("bltz_taken", 32'(last_taken), 32'd1);
    check("bltz_target", last_target, 32'h0000_A00C);
    do_br(3'd2, 32'h0000_B000, 16'h0002, 32'd6, 32'd6, 1, 0, 1, 0);
    check("bne_eq_taken", 32'(last_taken), 32'd0);
    check("bne_eq_target", last_target, 32'h0000_B008);
`else
    do_br(3'd2, 32'h0000_B000, 16'h0002, 32'd6, 32'd7, 3, 0, 3, 0);
    check("type2_taken", 32'(last_taken), 32'd0);
    check("type2_target", last_target, 32'h0000_B008);
    check("type2_no_err", 32'(err_timeout), 32'd0);
`endif
    do_br(3'd7, 32'h0000_C000, 16'h0002, 32'd6, 32'd6, 9, 0, 9, 0);
    check("type7_target", last_target, 32'h0000_C008);
    check("type7_no_err", 32'(err_timeout), 32'd0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      v = pick();
      do_br(3'($urandom_range(0, 7)), $urandom, 16'($urandom), v,
            ($urandom_range(0, 1) == 1) ? v : pick(),
            $urandom_range(1, 6), $urandom_range(0, 2),
            $urandom_range(1, 6), $urandom_range(0, 2));
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
